// File: rtl/game_pkg.sv
// Shared types for the goose-run game controller.
// Holds the game state encoding, lives width and a state-name helper.
package game_pkg;

    typedef enum logic [2:0] {
        ST_MENU    = 3'd0,
        ST_PLAY    = 3'd1,
        ST_PAUSE   = 3'd2,
        ST_RESPAWN = 3'd3,
        ST_OVER    = 3'd4
    } game_state_e;

    localparam int LIVES_W = 4;

    function automatic string state_name(input logic [2:0] s);
        case (s)
            3'd0:    return "MENU";
            3'd1:    return "PLAY";
            3'd2:    return "PAUSE";
            3'd3:    return "RESPAWN";
            3'd4:    return "OVER";
            default: return "ILLEGAL";
        endcase
    endfunction

endpackage

// File: rtl/game_flow_mixer_mux.sv
// Registered priority mixer: lowest-index active layer wins.
// Ports: clk, reset, video_on, layer_en, layer_rgb in; rgb out.
module layer_priority_mux #(
    parameter int                 NUM_LAYERS = 8,
    parameter int                 COLOR_W    = 12,
    parameter logic [COLOR_W-1:0] BG_COLOR   = '0
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          video_on,
    input  logic [NUM_LAYERS-1:0]         layer_en,
    input  logic [NUM_LAYERS*COLOR_W-1:0] layer_rgb,
    output logic [COLOR_W-1:0]            rgb
);

    logic [COLOR_W-1:0] rgb_d, rgb_q;

    // Walk from lowest priority up so index 0 is written last.
    always_comb begin
        rgb_d = BG_COLOR;
        for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
            if (layer_en[i]) begin
                rgb_d = layer_rgb[i*COLOR_W +: COLOR_W];
            end
        end
        if (!video_on) begin
            rgb_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rgb_q <= '0;
        end else begin
            rgb_q <= rgb_d;
        end
    end

    assign rgb = rgb_q;

endmodule

// File: rtl/game_flow_mixer.sv
// Game controller FSM, lives/score/high-score and pixel mixer.
// Ports: clk, reset, tick, buttons, collisions, layers in; rgb, state, score out.
module game_flow_mixer
    import game_pkg::*;
#(
    parameter int                 NUM_LAYERS    = 8,
    parameter int                 COLOR_W       = 12,
    parameter int                 SCORE_W       = 16,
    parameter int                 LIVES         = 3,
    parameter int                 RESPAWN_TICKS = 5,
    parameter logic [COLOR_W-1:0] BG_COLOR      = 12'h000
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          tick,
    input  logic                          start_btn,
    input  logic                          pause_btn,
    input  logic                          video_on,
    input  logic                          collide_a,
    input  logic                          collide_b,
    input  logic [NUM_LAYERS-1:0]         layer_en,
    input  logic [NUM_LAYERS*COLOR_W-1:0] layer_rgb,
    output logic [COLOR_W-1:0]            rgb,
    output logic [2:0]                    state,
    output logic                          play,
    output logic [SCORE_W-1:0]            score,
    output logic [SCORE_W-1:0]            score_hi,
    output logic [LIVES_W-1:0]            lives,
    output logic                          new_hi
);

    localparam logic [LIVES_W-1:0] LIVES_INIT = LIVES_W'(LIVES);
    localparam logic [7:0]         RSP_INIT   = 8'(RESPAWN_TICKS);

    game_state_e        state_q, state_d;
    logic [SCORE_W-1:0] score_q, score_d;
    logic [SCORE_W-1:0] hi_q, hi_d;
    logic [LIVES_W-1:0] lives_q, lives_d;
    logic [7:0]         cnt_q, cnt_d;
    logic               new_hi_q, new_hi_d;
    logic               hit_q, hit_d;
    logic               start_prev_q, start_prev_d;
    logic               pause_prev_q, pause_prev_d;

    logic coll, start_press, pause_press;

    assign coll        = collide_a & collide_b & video_on;
    assign start_press = start_btn & ~start_prev_q;
    assign pause_press = pause_btn & ~pause_prev_q;

    always_comb begin
        state_d      = state_q;
        score_d      = score_q;
        hi_d         = hi_q;
        lives_d      = lives_q;
        cnt_d        = cnt_q;
        new_hi_d     = new_hi_q;
        start_prev_d = start_prev_q;
        pause_prev_d = pause_prev_q;

        // A collision on the consuming tick survives into the latch.
        if (state_q != ST_PLAY) begin
            hit_d = 1'b0;
        end else if (tick) begin
            hit_d = coll;
        end else begin
            hit_d = hit_q | coll;
        end

        if (tick) begin
            start_prev_d = start_btn;
            pause_prev_d = pause_btn;
            if (score_q > hi_q) begin
                hi_d     = score_q;
                new_hi_d = 1'b1;
            end
            case (state_q)
                ST_MENU: begin
                    if (start_press) begin
                        state_d  = ST_PLAY;
                        score_d  = '0;
                        lives_d  = LIVES_INIT;
                        new_hi_d = 1'b0;
                    end
                end
                ST_PLAY: begin
                    if (hit_q) begin
                        if (lives_q == 4'd1) begin
                            state_d = ST_OVER;
                            lives_d = '0;
                        end else begin
                            state_d = ST_RESPAWN;
                            lives_d = lives_q - 4'd1;
                            cnt_d   = RSP_INIT;
                        end
                    end else if (pause_press) begin
                        state_d = ST_PAUSE;
                    end else if (score_q != {SCORE_W{1'b1}}) begin
                        score_d = score_q + 1'b1;
                    end
                end
                ST_PAUSE: begin
                    if (pause_press) begin
                        state_d = ST_PLAY;
                    end
                end
                ST_RESPAWN: begin
                    cnt_d = cnt_q - 8'd1;
                    if (cnt_q == 8'd1) begin
                        state_d = ST_PLAY;
                    end
                end
                ST_OVER: begin
                    if (start_press) begin
                        state_d = ST_MENU;
                    end
                end
                default: state_d = ST_MENU;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_MENU;
            score_q      <= '0;
            hi_q         <= '0;
            lives_q      <= LIVES_INIT;
            cnt_q        <= '0;
            new_hi_q     <= 1'b0;
            hit_q        <= 1'b0;
            start_prev_q <= 1'b0;
            pause_prev_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            score_q      <= score_d;
            hi_q         <= hi_d;
            lives_q      <= lives_d;
            cnt_q        <= cnt_d;
            new_hi_q     <= new_hi_d;
            hit_q        <= hit_d;
            start_prev_q <= start_prev_d;
            pause_prev_q <= pause_prev_d;
        end
    end

    assign state    = state_q;
    assign play     = (state_q == ST_PLAY);
    assign score    = score_q;
    assign score_hi = hi_q;
    assign lives    = lives_q;
    assign new_hi   = new_hi_q;

    layer_priority_mux #(
        .NUM_LAYERS(NUM_LAYERS),
        .COLOR_W   (COLOR_W),
        .BG_COLOR  (BG_COLOR)
    ) u_mux (
        .clk      (clk),
        .reset    (reset),
        .video_on (video_on),
        .layer_en (layer_en),
        .layer_rgb(layer_rgb),
        .rgb      (rgb)
    );

endmodule

// File: tb/tb_game_flow_mixer.sv
// Directed bench for game_flow_mixer with a per-cycle reference model.
// Literal checks pin key points of the game script and the mixer.
module tb_game_flow_mixer;
    import game_pkg::*;

    localparam int NL = 8;
    localparam int CW = 12;
    localparam int SW = 16;
    localparam logic [CW-1:0] BG = 12'h00F;

    localparam int M_MENU = 0;
    localparam int M_PLAY = 1;
    localparam int M_PAUSE = 2;
    localparam int M_RSP = 3;
    localparam int M_OVER = 4;

    logic clk = 0;
    logic reset = 1;
    logic tick = 0;
    logic start_btn = 0;
    logic pause_btn = 0;
    logic video_on = 0;
    logic collide_a = 0;
    logic collide_b = 0;
    logic [NL-1:0] layer_en = '0;
    logic [NL*CW-1:0] layer_rgb = '0;
    logic [CW-1:0] rgb;
    logic [2:0] state;
    logic play;
    logic [SW-1:0] score, score_hi;
    logic [3:0] lives;
    logic new_hi;

    game_flow_mixer #(
        .NUM_LAYERS(NL), .COLOR_W(CW), .SCORE_W(SW),
        .LIVES(3), .RESPAWN_TICKS(5), .BG_COLOR(BG)
    ) dut (
        .clk(clk), .reset(reset), .tick(tick),
        .start_btn(start_btn), .pause_btn(pause_btn),
        .video_on(video_on),
        .collide_a(collide_a), .collide_b(collide_b),
        .layer_en(layer_en), .layer_rgb(layer_rgb),
        .rgb(rgb), .state(state), .play(play),
        .score(score), .score_hi(score_hi),
        .lives(lives), .new_hi(new_hi)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_bad = 0;
    bit cmp_en = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h at %0t",
                     nm, act, exp, $time);
        end
    endtask

    // Reference model: game rules applied per clock edge.
    int m_st, m_score, m_hi, m_lives, m_cnt, m_rgb;
    bit m_newhi, m_hit, m_sp, m_pp;

    function automatic int mix_ref();
        if (!video_on) return 0;
        for (int i = 0; i < NL; i++)
            if (layer_en[i]) return int'(layer_rgb[i*CW +: CW]);
        return int'(BG);
    endfunction

    always @(posedge clk) begin
        bit c, sp, pp, was_play;
        if (reset) begin
            m_st = M_MENU; m_score = 0; m_hi = 0;
            m_lives = 3; m_cnt = 0; m_rgb = 0;
            m_newhi = 0; m_hit = 0; m_sp = 0; m_pp = 0;
        end else begin
            m_rgb = mix_ref();
            c = collide_a & collide_b & video_on;
            was_play = (m_st == M_PLAY);
            if (tick) begin
                sp = start_btn && !m_sp;
                pp = pause_btn && !m_pp;
                m_sp = start_btn;
                m_pp = pause_btn;
                if (m_score > m_hi) begin
                    m_hi = m_score;
                    m_newhi = 1;
                end
                if (m_st == M_MENU) begin
                    if (sp) begin
                        m_st = M_PLAY; m_score = 0;
                        m_lives = 3; m_newhi = 0;
                    end
                end else if (m_st == M_PLAY) begin
                    if (m_hit) begin
                        m_lives = m_lives - 1;
                        if (m_lives == 0) m_st = M_OVER;
                        else begin
                            m_st = M_RSP;
                            m_cnt = 5;
                        end
                    end else if (pp) m_st = M_PAUSE;
                    else if (m_score < 65535) m_score++;
                end else if (m_st == M_PAUSE) begin
                    if (pp) m_st = M_PLAY;
                end else if (m_st == M_RSP) begin
                    if (m_cnt == 1) m_st = M_PLAY;
                    m_cnt = m_cnt - 1;
                end else if (m_st == M_OVER) begin
                    if (sp) m_st = M_MENU;
                end
                m_hit = was_play ? c : 1'b0;
            end else begin
                m_hit = was_play ? (m_hit | c) : 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("rgb", int'(rgb), m_rgb);
            chk("state", int'(state), m_st);
            chk("play", int'(play), int'(m_st == M_PLAY));
            chk("score", int'(score), m_score);
            chk("score_hi", int'(score_hi), m_hi);
            chk("lives", int'(lives), m_lives);
            chk("new_hi", int'(new_hi), int'(m_newhi));
        end
    end

    task automatic tick1();
        @(negedge clk); tick = 1;
        @(negedge clk); tick = 0;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick1();
    endtask

    task automatic hit_pulse();
        @(negedge clk);
        video_on = 1; collide_a = 1; collide_b = 1;
        @(negedge clk);
        collide_a = 0; collide_b = 0;
    endtask

    initial begin
        repeat (2) @(negedge clk);
        reset = 0;
        cmp_en = 1;
        chk("rst_state", int'(state), M_MENU);
        chk("rst_lives", int'(lives), 3);
        chk("rst_score", int'(score), 0);
        chk("rst_rgb", int'(rgb), 0);

        start_btn = 1;
        tick1();
        chk("start_play", int'(state), M_PLAY);
        chk("start_score", int'(score), 0);
        ticks(2);
        chk("held_once", int'(state), M_PLAY);
        chk("held_score", int'(score), 2);
        start_btn = 0;
        ticks(8);
        chk("score10", int'(score), 10);
        chk("hi9", int'(score_hi), 9);
        tick1();
        chk("hi10", int'(score_hi), 10);
        chk("newhi", int'(new_hi), 1);

        hit_pulse();
        tick1();
        chk("rsp_state", int'(state), M_RSP);
        chk("rsp_lives", int'(lives), 2);
        hit_pulse();
        ticks(4);
        chk("rsp_hold", int'(state), M_RSP);
        tick1();
        chk("rsp_done", int'(state), M_PLAY);
        chk("rsp_lives2", int'(lives), 2);

        pause_btn = 1;
        tick1();
        chk("paused", int'(state), M_PAUSE);
        ticks(4);
        chk("pause_held", int'(state), M_PAUSE);
        chk("pause_score", int'(score), 11);
        pause_btn = 0;
        tick1();
        pause_btn = 1;
        tick1();
        chk("unpause", int'(state), M_PLAY);
        pause_btn = 0;
        tick1();

        hit_pulse();
        tick1();
        chk("lives1", int'(lives), 1);
        ticks(5);
        hit_pulse();
        pause_btn = 1;
        tick1();
        chk("over", int'(state), M_OVER);
        chk("over_lives", int'(lives), 0);
        pause_btn = 0;
        start_btn = 1;
        tick1();
        chk("to_menu", int'(state), M_MENU);
        start_btn = 0;
        tick1();
        start_btn = 1;
        tick1();
        start_btn = 0;
        chk("replay", int'(state), M_PLAY);
        chk("replay_score", int'(score), 0);
        chk("hi_kept", int'(score_hi), 12);

        @(negedge clk);
        video_on = 1;
        layer_en = 8'b0000_0110;
        layer_rgb = '0;
        layer_rgb[1*CW +: CW] = 12'hF00;
        layer_rgb[2*CW +: CW] = 12'h0F0;
        @(negedge clk);
        chk("mix_pri", int'(rgb), 12'hF00);
        layer_en = 8'b1000_0000;
        layer_rgb[7*CW +: CW] = 12'h123;
        @(negedge clk);
        chk("mix_l7", int'(rgb), 12'h123);
        layer_en = '0;
        @(negedge clk);
        chk("mix_bg", int'(rgb), int'(BG));
        layer_en = 8'b0000_0110;
        video_on = 0;
        @(negedge clk);
        chk("mix_blank", int'(rgb), 0);

        ticks(3);
        reset = 1; tick = 1;
        @(negedge clk);
        reset = 0; tick = 0;
        chk("rst_tick_st", int'(state), M_MENU);
        chk("rst_tick_hi", int'(score_hi), 0);
        chk("rst_tick_lv", int'(lives), 3);
        repeat (3) @(negedge clk);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
